// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   - DefDataW : default operand width
//   - state_e  : controller states (idle / run / done)
//   - Booth*   : 3-bit Booth digit codes {b[2k+1], b[2k], b[2k-1]}
package mul_pkg;

    localparam int unsigned DefDataW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [2:0] BoothZero0 = 3'b000;
    localparam logic [2:0] BoothPosA0 = 3'b001;
    localparam logic [2:0] BoothPosA1 = 3'b010;
    localparam logic [2:0] BoothPos2A = 3'b011;
    localparam logic [2:0] BoothNeg2A = 3'b100;
    localparam logic [2:0] BoothNegA0 = 3'b101;
    localparam logic [2:0] BoothNegA1 = 3'b110;
    localparam logic [2:0] BoothZero1 = 3'b111;

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator.
// Ports:
//   digit : 3-bit Booth digit {b[2k+1], b[2k], b[2k-1]}
//   mcand : signed multiplicand (DATA_W bits)
//   pp    : signed partial product in {0, +A, +2A, -A, -2A}, DATA_W+2 bits
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic        [2:0]        digit,
    input  logic        [DATA_W-1:0] mcand,
    output logic signed [DATA_W+1:0] pp
);

    // Two guard bits keep +/-2A exact even for the most-negative multiplicand.
    logic signed [DATA_W+1:0] a_ext;
    assign a_ext = {{2{mcand[DATA_W-1]}}, mcand};

    always_comb begin
        pp = '0;
        unique case (digit)
            BoothZero0, BoothZero1: pp = '0;
            BoothPosA0, BoothPosA1: pp = a_ext;
            BoothPos2A:             pp = a_ext <<< 1;
            BoothNeg2A:             pp = -(a_ext <<< 1);
            BoothNegA0, BoothNegA1: pp = -a_ext;
            default:                pp = '0;
        endcase
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential radix-4 Booth multiply controller: one Booth digit retired per clock,
// signed 2*DATA_W product written to hi/lo with a busy/done handshake.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   start        : request, sampled only while idle
//   op_a, op_b   : signed multiplicand / multiplier, latched on accept
//   busy         : high while digits are being accumulated
//   done         : one-cycle pulse after the result is loaded
//   hi, lo       : registered upper / lower product halves
// Build option: define MUL_EARLY_TERM_EN to finish as soon as all remaining
// multiplier digits recode to zero (result is unchanged, latency shrinks).
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned N  = DATA_W / 2;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * DATA_W;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    state_e              state_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [PW-1:0]       acc_q;
    logic [KW-1:0]       k_q;

    // Multiplier with the implicit b[-1] = 0 appended below bit 0.
    logic [DATA_W:0]     b_ext;
    logic [KW:0]         shamt;
    logic [2:0]          digit;
    logic signed [DATA_W+1:0] pp;
    logic [PW-1:0]       pp_ext;
    logic [PW-1:0]       sum;
    logic                last;

    assign b_ext = {b_q, 1'b0};
    assign shamt = {k_q, 1'b0};
    assign digit = b_ext[shamt +: 3];

    booth_pp_gen #(
        .DATA_W (DATA_W)
    ) u_pp_gen (
        .digit (digit),
        .mcand (a_q),
        .pp    (pp)
    );

    assign pp_ext = {{(PW - DATA_W - 2){pp[DATA_W+1]}}, pp} << shamt;
    assign sum    = acc_q + pp_ext;

`ifdef MUL_EARLY_TERM_EN
    // Arithmetic shift by 2k+1 leaves b[DATA_W-1:2k+1] in the low bits with the
    // sign copied above, so they are all equal exactly when the result is 0 or -1.
    logic [DATA_W-1:0] b_rest;
    assign b_rest = $signed(b_q) >>> {k_q, 1'b1};
    assign last   = (k_q == KLast) || (b_rest == '0) || (b_rest == '1);
`else
    assign last   = (k_q == KLast);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        acc_q   <= '0;
                        k_q     <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= sum;
                    k_q   <= k_q + KW'(1);
                    if (last) begin
                        {hi, lo} <= sum;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl (DATA_W = 32). The reference is a plain
// 64-bit signed multiply; expected latency follows from the multiplier bits.
module tb_mul_seq_ctrl;

    localparam int unsigned W = 32;
    localparam int N = W / 2;
`ifdef MUL_EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] last_prod = '0;

    always #5 clock = ~clock;

    mul_seq_ctrl #(
        .DATA_W (W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // RUN cycles: N, or with early termination the first k where b[W-1:2k+1] are equal, plus 1.
    function automatic int exp_runs(input logic [31:0] b);
        if (!EarlyTerm) return N;
        for (int k = 0; k < N; k++) begin
            bit eq = 1'b1;
            for (int i = 2 * k + 1; i < W; i++) if (b[i] != b[W-1]) eq = 1'b0;
            if (eq) return k + 1;
        end
        return N;
    endfunction

    // Issue one request and follow it to one cycle past done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] prev,
                          output logic [63:0] prod, output int run_cyc, output int busy_cyc,
                          output int hold_bad, output logic post_done, output logic post_busy);
        @(negedge clock);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom;  // must not disturb the latched operands
        run_cyc = 0; busy_cyc = 0; hold_bad = 0;
        while (run_cyc < 3 * N) begin
            if (busy === 1'b1) busy_cyc++;
            if ({hi, lo} !== prev) hold_bad++;
            @(posedge clock); #1;
            run_cyc++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) run_cyc = 999;
        prod = {hi, lo};
        @(posedge clock); #1;
        post_done = done;
        post_busy = busy;
    endtask

    task automatic test_reset();
        logic [63:0] prod; int rc, bc, hb; logic pd, pb; int pulses;
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++;
            $display("FAIL por_flags got busy/done=%b want 00", {busy, done}); end
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++;
            $display("FAIL por_hilo got %h want 0", {hi, lo}); end
        reset = 1'b0;
        // leave a nonzero result so the mid-run reset has something to clear
        run_op(32'h1234_5678, 32'h0000_5678, 64'h0, prod, rc, bc, hb, pd, pb);
        n_cmp++; if (prod !== ref_mul(32'h1234_5678, 32'h0000_5678)) begin n_bad++;
            $display("FAIL pre_reset_prod got %h want %h", prod, ref_mul(32'h1234_5678, 32'h5678)); end
        @(negedge clock);
        op_a = 32'hFFFF_FFF9; op_b = 32'd11; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(posedge clock); #1;
            n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++;
                $display("FAIL midrun_reset_flags[%0d] got %b want 00", e, {busy, done}); end
            n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++;
                $display("FAIL midrun_reset_hilo[%0d] got %h want 0", e, {hi, lo}); end
        end
        @(negedge clock); reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(posedge clock); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++;
            $display("FAIL discarded_op_activity got %0d want 0", pulses); end
        run_op(32'd2, 32'd3, 64'h0, prod, rc, bc, hb, pd, pb);
        n_cmp++; if (prod !== 64'h6) begin n_bad++;
            $display("FAIL post_reset_2x3 got %h want 6", prod); end
        n_cmp++; if (rc !== exp_runs(32'd3)) begin n_bad++;
            $display("FAIL post_reset_latency got %0d want %0d", rc, exp_runs(32'd3)); end
        n_cmp++; if (pd !== 1'b0) begin n_bad++;
            $display("FAIL post_reset_single_done got %b want 0", pd); end
        last_prod = 64'h6;
    endtask

    task automatic test_basic();
        logic [63:0] prod; int rc, bc, hb; logic pd, pb;
        run_op(32'd3, 32'd5, last_prod, prod, rc, bc, hb, pd, pb);
        n_cmp++; if (prod !== 64'hF) begin n_bad++;
            $display("FAIL basic_3x5 got %h want f", prod); end
        n_cmp++; if (rc !== exp_runs(32'd5)) begin n_bad++;
            $display("FAIL basic_latency got %0d want %0d", rc, exp_runs(32'd5)); end
        n_cmp++; if (bc !== exp_runs(32'd5)) begin n_bad++;
            $display("FAIL basic_busy_cycles got %0d want %0d", bc, exp_runs(32'd5)); end
        n_cmp++; if (hb !== 0) begin n_bad++;
            $display("FAIL basic_hilo_hold got %0d early changes want 0", hb); end
        n_cmp++; if ({pd, pb} !== 2'b00) begin n_bad++;
            $display("FAIL basic_after_done got done/busy=%b want 00", {pd, pb}); end
        last_prod = 64'hF;
    endtask

    task automatic test_corners();
        logic [31:0] ta [6] = '{32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                32'd1234, 32'h1234_5678};
        logic [31:0] tb [6] = '{32'd6, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'd0, 32'h4000_0000};
        logic [63:0] te [6] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'h3FFF_FFFF_0000_0001,
                                64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000,
                                64'h0, 64'h048D_159E_0000_0000};
        int tl [6];
        logic [63:0] prod; int rc, bc, hb; logic pd, pb;
        tl = '{exp_runs(32'd6), N, N, EarlyTerm ? 1 : N, EarlyTerm ? 1 : N, N};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], last_prod, prod, rc, bc, hb, pd, pb);
            n_cmp++; if (prod !== te[i]) begin n_bad++;
                $display("FAIL corner_prod[%0d] got %h want %h", i, prod, te[i]); end
            n_cmp++; if (rc !== tl[i]) begin n_bad++;
                $display("FAIL corner_latency[%0d] got %0d want %0d", i, rc, tl[i]); end
            n_cmp++; if (hb !== 0 || pd !== 1'b0) begin n_bad++;
                $display("FAIL corner_handshake[%0d] got hold=%0d done=%b want 0/0", i, hb, pd); end
            last_prod = te[i];
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        // one-cycle pulse of a second request in the middle of a run
        @(negedge clock); op_a = 32'd4; op_b = 32'd4; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(negedge clock); start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3 * N) begin @(posedge clock); #1; cyc++; end
        n_cmp++; if ({hi, lo} !== 64'h10) begin n_bad++;
            $display("FAIL pulse_ignored_prod got %h want 10", {hi, lo}); end
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++;
            $display("FAIL pulse_not_queued got busy/done=%b want 00", {busy, done}); end
        // request held high straight through a run
        @(negedge clock); op_a = 32'd4; op_b = 32'd4; start = 1'b1;
        @(posedge clock); #1; op_a = 32'd9; op_b = 32'd9;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3 * N) begin @(posedge clock); #1; cyc++; end
        n_cmp++; if ({hi, lo} !== 64'h10) begin n_bad++;
            $display("FAIL held_first_prod got %h want 10", {hi, lo}); end
        n_cmp++; if (cyc !== exp_runs(32'd4)) begin n_bad++;
            $display("FAIL held_first_latency got %0d want %0d", cyc, exp_runs(32'd4)); end
        @(posedge clock); #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++;
            $display("FAIL held_done_state got busy/done=%b want 00", {busy, done}); end
        @(posedge clock); #1; start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++;
            $display("FAIL held_accept_in_idle got busy=%b want 1", busy); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 3 * N) begin @(posedge clock); #1; cyc++; end
        n_cmp++; if ({hi, lo} !== 64'd81) begin n_bad++;
            $display("FAIL held_second_prod got %h want 51", {hi, lo}); end
        @(posedge clock); #1;
        last_prod = 64'd81;
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] a, b;
        logic [63:0] prod, want; int rc, bc, hb; logic pd, pb;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(0, 255);
                3: a = 32'h8000_0000;
                4: b = {$urandom_range(0, 1) ? 8'hFF : 8'h00, 24'($urandom)};
                default: ;
            endcase
            want = ref_mul(a, b);
            run_op(a, b, last_prod, prod, rc, bc, hb, pd, pb);
            n_cmp++; if (prod !== want) begin n_bad++;
                $display("FAIL rand_prod[%0d] a=%h b=%h got %h want %h", i, a, b, prod, want); end
            n_cmp++; if (rc !== exp_runs(b) || bc !== exp_runs(b)) begin n_bad++;
                $display("FAIL rand_latency[%0d] b=%h got %0d/%0d want %0d", i, b, rc, bc,
                         exp_runs(b)); end
            n_cmp++; if (hb !== 0 || {pd, pb} !== 2'b00) begin n_bad++;
                $display("FAIL rand_handshake[%0d] got hold=%0d done/busy=%b want 0/00", i, hb,
                         {pd, pb}); end
            last_prod = want;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential radix-4 Booth multiply controller for the CPU datapath. It accepts a multiply request from the control unit, captures both operands, and retires one Booth digit per clock. It accumulates the signed 64-bit product and writes it into the HI/LO result registers with a busy/done handshake. It replaces the single-cycle combinational multiplier on the critical path with a 16-cycle multi-cycle operation the control FSM stalls on.

## Interface
- DATA_W, 32, operand width; must be even and ≥ 4; product width is 2·DATA_W; digit count N = DATA_W/2
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- op_a  input  DATA_W  multiplicand, signed two's complement
- op_b  input  DATA_W  multiplier, signed two's complement
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high in DONE
- hi  output  DATA_W  upper product half, registered
- lo  output  DATA_W  lower product half, registered

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE: on start=1, latch op_a/op_b, clear the accumulator, set digit counter k=0, and go to RUN.
  - RUN: each cycle, recode digit k = {b[2k+1], b[2k], b[2k-1]}, with b[-1]=0. Add the partial product, sign-extended to 2·DATA_W and shifted left 2k, to the accumulator. Then k←k+1.
  - RUN exit: after digit N−1 (or on early termination), load {hi,lo} from the final sum on the same edge and go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Booth digit table:
  - 000 and 111 → 0
  - 001 and 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101 and 110 → −A
- Partial products are DATA_W+2 bits wide so that ±2A of the most-negative operand is exact.
- start is ignored in RUN and DONE. No queuing; the requester holds start until it sees busy.
- Operands are latched at accept. Input changes during RUN have no effect.
- hi/lo hold their last result until the next completion. They are never partially updated.
- Reset in any state returns to IDLE. It clears busy, done, hi, lo, the accumulator and k. An in-flight operation is discarded with no done pulse.
- Reset values: busy=0, done=0, hi=0, lo=0.

## Timing
- Let start be sampled high in IDLE at edge t.
  - busy rises after edge t.
  - Accumulations happen at edges t+1 … t+N.
  - hi/lo are valid after edge t+N.
  - done is high between edges t+N and t+N+1.
  - Back in IDLE after edge t+N+1; the next start is sampled no earlier than edge t+N+1.
- Fixed latency without early termination: N RUN cycles (16 for DATA_W=32). Throughput is one product per N+2 cycles.
- Both done and hi/lo are registered outputs; there is no combinational path from inputs to outputs.

## Configuration
- MUL_EARLY_TERM_EN
  - Defined: at each RUN edge, after accumulating digit k, check whether multiplier bits b[DATA_W−1 : 2k+1] are all equal. If so, every remaining digit recodes to 0; load hi/lo and go to DONE on that edge.
  - Defined: latency is 1…N RUN cycles. Example: b=0 or b=−1 completes after 1 RUN cycle.
  - Undefined: always N RUN cycles.
  - Results are identical in both builds.

## Structure
- Package mul_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - the Booth digit code constants
  - the default DATA_W
- Sub-module booth_pp_gen: combinational; 3-bit digit plus multiplicand in, signed DATA_W+2 partial product out.
- The controller instantiates booth_pp_gen once, reused every cycle.

## Test plan
- Reset: assert reset for 2 cycles mid-RUN → busy=0, done=0, hi=0, lo=0 on the next cycle. The following request 2×3 gives hi=0x00000000, lo=0x00000006 with exactly one done pulse.
- 3 × 5 → hi=0x00000000, lo=0x0000000F. Without the macro, done arrives exactly 16 cycles after the accept edge and busy stays high for 16 cycles.
- −7 × 6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6. Also 0x7FFFFFFF × 0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. Also 0x80000000 × 0x00000001 → hi=0xFFFFFFFF, lo=0x80000000.
- Second start with 9×9 pulsed during RUN of 4×4 → lo=0x10 only, exactly one done pulse. The held request is accepted only after returning to IDLE.
- With MUL_EARLY_TERM_EN: 1234 × 0 → done after 1 RUN cycle, hi=lo=0. 5 × 3 → done after 2 RUN cycles, lo=0xF. 0x12345678 × 0x40000000 → 16 RUN cycles, hi=0x048D159E, lo=0x00000000.
